ccff_chain_loader: RTL



---
 rtl/ccff_chain_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ccff_chain_loader.sv
// Bitstream loader for a tile configuration chain: takes words over valid/ready,
// shifts them bit-serially into the chain and counts the ones returned on the tail.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 18,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 5
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  tail_ones
);

  localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int WC_W      = $clog2(NUM_WORDS + 1);
  localparam int IDX_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0] LEN_C       = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT_C  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WC_W-1:0]  NUM_WORDS_C = WC_W'(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX_C  = IDX_W'(WORD_W - 1);
  localparam logic             MULTI_BIT_C = (WORD_W > 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              buf_valid_q, buf_valid_d;
  logic [WC_W-1:0]   words_q, words_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              head_q, head_d;
  logic              cen_q, cen_d;
  logic [CNT_W-1:0]  tail_q, tail_d;

  logic run;
  logic bits_left;
  logic buf_last;
  logic accept;

  assign run       = (state_q == S_RUN);
  assign bits_left = (bit_cnt_q != LEN_C);
  // The buffered bit being issued is its last useful one: end of word or end of chain.
  assign buf_last  = buf_valid_q && ((idx_q == LAST_IDX_C) || (bit_cnt_q == LAST_BIT_C));
  assign in_ready  = run && (words_q != NUM_WORDS_C) && (!buf_valid_q || buf_last);
  assign accept    = in_valid && in_ready;

  // NOTE: every variable gets its default before any branch so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    idx_d       = idx_q;
    buf_valid_d = buf_valid_q;
    words_d     = words_q;
    bit_cnt_d   = bit_cnt_q;
    head_d      = head_q;
    cen_d       = 1'b0;
    tail_d      = tail_q;

    // Tail sample is the pre-shift bit, taken on every edge where the chain shifts.
    if (cen_q && ccff_tail) begin
      tail_d = tail_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          tail_d      = '0;
          bit_cnt_d   = '0;
          words_d     = '0;
          idx_d       = '0;
          buf_valid_d = 1'b0;
        end
      end

      S_RUN: begin
        if (buf_valid_q && bits_left) begin
          head_d    = buf_q[idx_q];
          cen_d     = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (buf_last) begin
            buf_valid_d = accept;
            if (accept) begin
              buf_d = in_data;
              idx_d = '0;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (accept) begin
          // Empty buffer: issue bit 0 straight from the bus and keep the rest.
          head_d      = in_data[0];
          cen_d       = 1'b1;
          bit_cnt_d   = bit_cnt_q + 1'b1;
          buf_d       = in_data;
          idx_d       = IDX_W'(1);
          buf_valid_d = MULTI_BIT_C && (bit_cnt_q != LAST_BIT_C);
        end

        if (accept) begin
          words_d = words_q + 1'b1;
        end

        if (!bits_left) begin
          state_d     = S_FIN;
          buf_valid_d = 1'b0;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      buf_valid_q <= 1'b0;
      words_q     <= '0;
      bit_cnt_q   <= '0;
      head_q      <= 1'b0;
      cen_q       <= 1'b0;
      tail_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_valid_q <= buf_valid_d;
      words_q     <= words_d;
      bit_cnt_q   <= bit_cnt_d;
      head_q      <= head_d;
      cen_q       <= cen_d;
      tail_q      <= tail_d;
    end
  end

  // NOTE: word data needs no reset; buf_valid_q alone decides whether it is ever read.
  always_ff @(posedge prog_clk) begin
    buf_q <= buf_d;
  end

  assign busy          = run;
  assign done          = (state_q == S_FIN);
  assign ccff_head     = head_q;
  assign config_enable = cen_q;
  assign tail_ones     = tail_q;

endmodule
